// File: rtl/id_hazard_if.sv
// Decode-stage hazard controller interface: IF/ID instruction info and branch
// resolution in, pipeline enables and performance counters out.
interface id_hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_mem_read;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_mem_read, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_mem_read, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Load-use hazard detection and taken-branch flush sequencing for the decode
// stage, with saturating stall/flush cycle counters.
module id_hazard_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES     = 1,
  parameter int unsigned CNT_W            = 16
) (
  input logic        clk,
  input logic        reset,
  id_hazard_if.slave bus
);

  localparam bit         CHECK_MEM   = (LOAD_USE_BUBBLES == 2);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [1:0] FCNT_INIT   = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       fcnt;
  logic             ex_v;
  logic [4:0]       ex_rd;
  logic             mem_v;
  logic [4:0]       mem_rd;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic flush;
  logic stall;
  logic issue;
  logic ex_hit;
  logic mem_hit;

  // A tracked load conflicts if its destination is a live source of IF/ID; $0 never does.
  function automatic logic match(input logic v, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt);
    return v & (rd != 5'd0) & ((rs == rd) | (uses_rt & (rt == rd)));
  endfunction

  // Reset overrides everything, then flush, then stall.
  always_comb begin
    flush   = 1'b0;
    stall   = 1'b0;
    issue   = 1'b0;
    ex_hit  = match(ex_v, ex_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    mem_hit = CHECK_MEM & match(mem_v, mem_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    if (!reset) begin
      flush = (state == FLUSH) | bus.ex_branch_taken;
      stall = bus.id_valid & ~flush & (ex_hit | mem_hit);
    end
    issue = bus.id_valid & ~stall & ~flush;
  end

  assign bus.pc_write     = ~stall;
  assign bus.if_id_write  = ~stall;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = stall | flush;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

  // Flush sequencer: the RUN cycle that sees the branch is the first flush cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (bus.ex_branch_taken && MULTI_FLUSH) begin
            state <= FLUSH;
            fcnt  <= FCNT_INIT;
          end
        end
        FLUSH: begin
          fcnt <= fcnt - 2'd1;
          if (fcnt <= 2'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= 2'd0;
        end
      endcase
    end
  end

  // Loads advance EX -> MEM; the load ahead of a branch keeps moving.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v   <= 1'b0;
      ex_rd  <= 5'd0;
      mem_v  <= 1'b0;
      mem_rd <= 5'd0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      if (issue && bus.id_mem_read) begin
        ex_v  <= 1'b1;
        ex_rd <= bus.id_rt;
      end else begin
        ex_v  <= 1'b0;
        ex_rd <= 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
